// File: rtl/prog_loader.sv
// -----------------------------------------------------------------------------
// prog_loader
//
// Instruction-memory writer fed by a byte stream from a host link. A frame is
// a 2-byte word count N (MSB first) followed by N 32-bit words, each sent MSB
// first. Words are written to consecutive word addresses starting at 0 while
// the processor is held in reset; the hold is released once all N words are
// written.
//
// Ports:
//   clk           system clock, all state changes on the rising edge
//   rst           synchronous active-high reset
//   load_req      one-cycle pulse that starts a load (ignored mid-frame)
//   rx_data       incoming byte
//   rx_valid      rx_data is valid this cycle
//   rx_ready      loader accepts a byte this cycle
//   wr_en         instruction memory write strobe, one cycle per word
//   wr_addr       word address being written
//   wr_data       instruction word being written
//   cpu_hold      hold processor in reset while high
//   done          load completed successfully (sticky until next load)
//   err           declared length exceeded DEPTH (sticky until next load)
//   words_loaded  words written in the current or last load
// -----------------------------------------------------------------------------
module prog_loader #(
  parameter int unsigned DEPTH  = 64,
  parameter int unsigned ADDR_W = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_req,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              rx_ready,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [31:0]       wr_data,
  output logic              cpu_hold,
  output logic              done,
  output logic              err,
  output logic [15:0]       words_loaded
);

  typedef enum logic [2:0] {
    StIdle,
    StLenHi,
    StLenLo,
    StData,
    StFlush,
    StDone,
    StErr
  } state_e;

  // 17 bits so that DEPTH itself (e.g. 65536) still compares correctly.
  localparam logic [16:0] DepthW = 17'(DEPTH);

  state_e            state_q;
  logic [15:0]       len_q;
  logic [1:0]        byte_cnt_q;
  logic [ADDR_W-1:0] word_idx_q;
  // Only the first three bytes of a word need storing; the fourth arrives
  // on rx_data in the same cycle the word is handed to the write port.
  logic [23:0]       asm_q;

  logic        accept;
  logic [15:0] len_full;
  logic [31:0] word_full;
  logic        last_word;

  assign accept    = rx_valid && rx_ready;
  assign len_full  = {len_q[15:8], rx_data};
  assign word_full = {asm_q, rx_data};
  assign last_word = ({{(16 - ADDR_W){1'b0}}, word_idx_q} == (len_q - 16'd1));

  // Single registered FSM: every output is a register updated together with
  // the state, so rx_ready/cpu_hold change on the same edge as the state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      len_q        <= '0;
      byte_cnt_q   <= '0;
      word_idx_q   <= '0;
      asm_q        <= '0;
      rx_ready     <= 1'b0;
      wr_en        <= 1'b0;
      wr_addr      <= '0;
      wr_data      <= '0;
      cpu_hold     <= 1'b0;
      done         <= 1'b0;
      err          <= 1'b0;
      words_loaded <= '0;
    end else begin
      // Write strobe lasts exactly one cycle; the word counts once written.
      if (wr_en) begin
        wr_en        <= 1'b0;
        words_loaded <= words_loaded + 16'd1;
      end

      unique case (state_q)
        StIdle, StDone, StErr: begin
          if (load_req) begin
            state_q      <= StLenHi;
            rx_ready     <= 1'b1;
            cpu_hold     <= 1'b1;
            done         <= 1'b0;
            err          <= 1'b0;
            words_loaded <= '0;
            byte_cnt_q   <= '0;
            word_idx_q   <= '0;
            len_q        <= '0;
          end
        end

        StLenHi: begin
          if (accept) begin
            len_q   <= {rx_data, 8'h00};
            state_q <= StLenLo;
          end
        end

        StLenLo: begin
          if (accept) begin
            len_q <= len_full;
            if (len_full == 16'd0) begin
              state_q  <= StDone;
              rx_ready <= 1'b0;
              cpu_hold <= 1'b0;
              done     <= 1'b1;
            end else if ({1'b0, len_full} > DepthW) begin
              // Processor stays held: there is no valid program in memory.
              state_q  <= StErr;
              rx_ready <= 1'b0;
              err      <= 1'b1;
            end else begin
              state_q    <= StData;
              byte_cnt_q <= '0;
              word_idx_q <= '0;
            end
          end
        end

        StData: begin
          if (accept) begin
            asm_q      <= word_full[23:0];
            byte_cnt_q <= byte_cnt_q + 2'd1;
            if (byte_cnt_q == 2'd3) begin
              wr_en   <= 1'b1;
              wr_addr <= word_idx_q;
              wr_data <= word_full;
              if (last_word) begin
                state_q  <= StFlush;
                rx_ready <= 1'b0;
              end else begin
                // Advanced here rather than after the write; the index is
                // not observed again until the next word's fourth byte.
                // Skipped on the last word so N==DEPTH never wraps it.
                word_idx_q <= word_idx_q + ADDR_W'(1);
              end
            end
          end
        end

        StFlush: begin
          state_q  <= StDone;
          cpu_hold <= 1'b0;
          done     <= 1'b1;
        end

        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_prog_loader.sv
// -----------------------------------------------------------------------------
// tb_prog_loader
//
// Self-checking bench for prog_loader. A frame-level model tracks how many
// bytes of the current frame have been accepted and derives the expected
// outputs from that count; every cycle the DUT outputs are compared with it.
// Directed tests add literal expectations on written words and timing.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_prog_loader;

  localparam int unsigned DEPTH  = 64;
  localparam int unsigned ADDR_W = 6;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              load_req = 1'b0;
  logic [7:0]        rx_data = 8'h00;
  logic              rx_valid = 1'b0;
  logic              rx_ready;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [31:0]       wr_data;
  logic              cpu_hold;
  logic              done;
  logic              err;
  logic [15:0]       words_loaded;

  prog_loader #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .load_req     (load_req),
    .rx_data      (rx_data),
    .rx_valid     (rx_valid),
    .rx_ready     (rx_ready),
    .wr_en        (wr_en),
    .wr_addr      (wr_addr),
    .wr_data      (wr_data),
    .cpu_hold     (cpu_hold),
    .done         (done),
    .err          (err),
    .words_loaded (words_loaded)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Frame-level model, updated on each rising edge from the bench's inputs.
  // ---------------------------------------------------------------------------
  bit          m_active;   // frame in progress, more bytes expected
  bit          m_final;    // last word's write still outstanding
  bit          m_wr_pend;  // a write is due in the coming cycle
  bit          m_done;
  bit          m_err;
  int          m_nbytes;
  int          m_len;
  int          m_words;
  logic [5:0]  m_wr_addr;
  logic [31:0] m_wr_data;
  logic [31:0] m_acc;
  bit          last_acc;   // a byte was accepted at the latest edge
  bit          chk_en = 1'b0;

  always @(posedge clk) begin : model
    bit busy;
    bit acc;
    int k;
    acc      = rx_valid && m_active;
    last_acc = 1'b0;
    if (rst) begin
      m_active  = 0; m_final = 0; m_wr_pend = 0; m_done = 0; m_err = 0;
      m_nbytes  = 0; m_len = 0; m_words = 0;
      m_wr_addr = '0; m_wr_data = '0; m_acc = '0;
      chk_en    = 1'b1;
    end else begin
      busy = m_active || m_final;
      if (m_wr_pend) begin
        m_words++;
        m_wr_pend = 0;
        if (m_final) begin
          m_final = 0;
          m_done  = 1;
        end
      end
      if (!busy && load_req) begin
        m_active = 1; m_nbytes = 0; m_len = 0;
        m_done   = 0; m_err = 0; m_words = 0;
      end else if (acc) begin
        last_acc = 1'b1;
        if (m_nbytes == 0) begin
          m_len = int'(rx_data) << 8;
        end else if (m_nbytes == 1) begin
          m_len = m_len | int'(rx_data);
          if (m_len == 0) begin
            m_active = 0;
            m_done   = 1;
          end else if (m_len > int'(DEPTH)) begin
            m_active = 0;
            m_err    = 1;
          end
        end else begin
          k     = m_nbytes - 2;
          m_acc = {m_acc[23:0], rx_data};
          if (k % 4 == 3) begin
            m_wr_pend = 1;
            m_wr_addr = 6'(k / 4);
            m_wr_data = m_acc;
            if (k / 4 == m_len - 1) begin
              m_active = 0;
              m_final  = 1;
            end
          end
        end
        m_nbytes++;
      end
    end
  end

  // Compare every output against the model, away from the active edge.
  always @(negedge clk) begin
    if (chk_en) begin
      check("rx_ready", 32'(rx_ready), 32'(m_active));
      check("wr_en", 32'(wr_en), 32'(m_wr_pend));
      check("wr_addr", 32'(wr_addr), 32'(m_wr_addr));
      check("wr_data", wr_data, m_wr_data);
      check("cpu_hold", 32'(cpu_hold), 32'(m_active || m_final || m_err));
      check("done", 32'(done), 32'(m_done));
      check("err", 32'(err), 32'(m_err));
      check("words_loaded", 32'(words_loaded), 32'(m_words));
    end
  end

  // Log of every write the DUT performs.
  logic [37:0] wlog[$];
  always @(negedge clk) begin
    if (wr_en === 1'b1) wlog.push_back({wr_addr, wr_data});
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers: each starts and ends just after a falling edge.
  // ---------------------------------------------------------------------------
  logic [31:0] frame_words[64];

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_load();
    load_req = 1'b1;
    @(negedge clk);
    load_req = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit gaps);
    int n;
    if (gaps) begin
      repeat ($urandom_range(0, 2)) begin
        rx_valid = 1'b0;
        @(negedge clk);
      end
    end
    rx_valid = 1'b1;
    rx_data  = b;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!last_acc && n < 20);
    if (!last_acc) begin
      checks++;
      failures++;
      $display("FAIL byte_accept: byte 0x%0h not accepted within %0d cycles", b, n);
    end
  endtask

  task automatic send_frame(input int n, input bit gaps);
    send_byte(8'(n >> 8), gaps);
    send_byte(8'(n), gaps);
    for (int i = 0; i < n; i++) begin
      for (int j = 3; j >= 0; j--) send_byte(8'(frame_words[i] >> (8 * j)), gaps);
    end
    rx_valid = 1'b0;
  endtask

  task automatic check_log(input string name, input int idx, input logic [5:0] addr,
                           input logic [31:0] data);
    if (idx >= wlog.size()) begin
      check({name, " present"}, 32'(wlog.size()), 32'(idx + 1));
    end else begin
      check({name, " addr"}, 32'(wlog[idx][37:32]), 32'(addr));
      check({name, " data"}, wlog[idx][31:0], data);
    end
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin : stim
    // Reset for two cycles.
    rst = 1'b1;
    idle(2);
    rst = 1'b0;
    check("reset cpu_hold", 32'(cpu_hold), 32'd0);
    check("reset rx_ready", 32'(rx_ready), 32'd0);
    check("reset done", 32'(done), 32'd0);
    check("reset words", 32'(words_loaded), 32'd0);

    // Nominal two-word load.
    wlog.delete();
    pulse_load();
    check("nom hold on", 32'(cpu_hold), 32'd1);
    frame_words[0] = 32'h20080005;
    frame_words[1] = 32'hAC080004;
    send_frame(2, 1'b0);
    check("nom last wr_en", 32'(wr_en), 32'd1);
    check("nom last addr", 32'(wr_addr), 32'd1);
    check("nom done early", 32'(done), 32'd0);
    check("nom hold flush", 32'(cpu_hold), 32'd1);
    idle(1);
    check("nom done", 32'(done), 32'd1);
    check("nom hold off", 32'(cpu_hold), 32'd0);
    check("nom words", 32'(words_loaded), 32'd2);
    check("nom nwrites", 32'(wlog.size()), 32'd2);
    check_log("nom w0", 0, 6'd0, 32'h20080005);
    check_log("nom w1", 1, 6'd1, 32'hAC080004);

    // Zero-length frame.
    wlog.delete();
    pulse_load();
    check("zero done cleared", 32'(done), 32'd0);
    send_frame(0, 1'b0);
    check("zero done", 32'(done), 32'd1);
    check("zero words", 32'(words_loaded), 32'd0);
    idle(2);
    check("zero nwrites", 32'(wlog.size()), 32'd0);

    // Oversize length, extra bytes ignored, then recovery.
    wlog.delete();
    pulse_load();
    send_byte(8'h00, 1'b0);
    send_byte(8'h41, 1'b0);
    rx_data = 8'h55;
    idle(3);
    rx_valid = 1'b0;
    check("over err", 32'(err), 32'd1);
    check("over hold", 32'(cpu_hold), 32'd1);
    check("over ready", 32'(rx_ready), 32'd0);
    pulse_load();
    check("over err cleared", 32'(err), 32'd0);
    frame_words[0] = 32'hDEADBEEF;
    send_frame(1, 1'b0);
    idle(2);
    check("over nwrites", 32'(wlog.size()), 32'd1);
    check_log("over w0", 0, 6'd0, 32'hDEADBEEF);
    check("over done", 32'(done), 32'd1);

    // Full depth with random gaps on rx_valid.
    wlog.delete();
    for (int i = 0; i < 64; i++) begin
      frame_words[i] = {8'(i), 8'(i * 7 + 3), 8'hA5 ^ 8'(i), 8'(255 - i)};
    end
    pulse_load();
    send_frame(64, 1'b1);
    idle(2);
    check("full nwrites", 32'(wlog.size()), 32'd64);
    for (int i = 0; i < 64; i++) check_log("full w", i, 6'(i), frame_words[i]);
    check("full words", 32'(words_loaded), 32'd64);
    check("full done", 32'(done), 32'd1);

    // Mid-load restart attempt (ignored) then reset.
    wlog.delete();
    pulse_load();
    send_byte(8'h00, 1'b0);
    send_byte(8'h03, 1'b0);
    send_byte(8'h11, 1'b0);
    send_byte(8'h22, 1'b0);
    send_byte(8'h33, 1'b0);
    send_byte(8'h44, 1'b0);
    send_byte(8'h55, 1'b0);
    send_byte(8'h66, 1'b0);
    rx_valid = 1'b0;
    pulse_load();
    check("mid still ready", 32'(rx_ready), 32'd1);
    check("mid still held", 32'(cpu_hold), 32'd1);
    rst = 1'b1;
    idle(1);
    rst = 1'b0;
    check("mid rst hold", 32'(cpu_hold), 32'd0);
    check("mid rst ready", 32'(rx_ready), 32'd0);
    check("mid rst wr_data", wr_data, 32'd0);
    check("mid rst words", 32'(words_loaded), 32'd0);
    idle(4);
    check("mid nwrites", 32'(wlog.size()), 32'd1);
    check_log("mid w0", 0, 6'd0, 32'h11223344);
    wlog.delete();
    frame_words[0] = 32'hCAFEF00D;
    frame_words[1] = 32'h01234567;
    pulse_load();
    send_frame(2, 1'b0);
    idle(2);
    check_log("mid reload w0", 0, 6'd0, 32'hCAFEF00D);
    check_log("mid reload w1", 1, 6'd1, 32'h01234567);
    check("mid reload done", 32'(done), 32'd1);

    // Back-to-back: new load straight from DONE.
    wlog.delete();
    pulse_load();
    check("b2b done cleared", 32'(done), 32'd0);
    frame_words[0] = 32'h00000000;
    send_frame(1, 1'b0);
    idle(2);
    check("b2b nwrites", 32'(wlog.size()), 32'd1);
    check_log("b2b w0", 0, 6'd0, 32'h00000000);
    check("b2b done", 32'(done), 32'd1);
    check("b2b words", 32'(words_loaded), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
